// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-ported RAM between fetch (IF) and load/store (DM) requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise DM has fixed priority over IF.
module ram_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIF_REQ,
  input  logic [31:0] iIF_ADDR,
  output logic        oIF_GNT,
  output logic        oIF_VALID,
  output logic [31:0] oIF_DATA,
  input  logic        iDM_REQ,
  input  logic        iDM_WR,
  input  logic [31:0] iDM_ADDR,
  input  logic [31:0] iDM_WDATA,
  output logic        oDM_GNT,
  output logic        oDM_VALID,
  output logic [31:0] oDM_RDATA,
  output logic        oRAM_CE,
  output logic        oRAM_WR,
  output logic [31:0] oRAM_ADDR,
  output logic [31:0] oRAM_DATA,
  input  logic [31:0] iRAM_DATA,
  output logic        oBUSY
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} stateT;
  localparam int LastI = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam logic [1:0] LAST = 2'(LastI);
  stateT state, nextState;
  logic winDm, latWr, grantIf, grantDm, idleNow;
  logic [1:0] cnt;
  logic [31:0] latAddr, latWdata, capData;
  // grants are masked during reset so every output reads 0 while iRST is high
  assign idleNow = (state == IDLE) && !iRST;
`ifdef ARB_ROUND_ROBIN_EN
  logic lastDm;
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) lastDm <= 1'b1;
    else if (grantIf || grantDm) lastDm <= grantDm;
  assign grantDm = idleNow && iDM_REQ && (!iIF_REQ || !lastDm);
`else
  assign grantDm = idleNow && iDM_REQ;
`endif
  assign grantIf = idleNow && iIF_REQ && !grantDm;
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = (iIF_REQ || iDM_REQ) ? ACCESS : IDLE;
      ACCESS:  nextState = (!latWr && RD_LAT > 1) ? WAIT : RESP;
      WAIT:    nextState = (cnt == LAST) ? RESP : WAIT;
      default: nextState = IDLE;
    endcase
  end
  always_comb begin
    oIF_GNT   = grantIf;
    oDM_GNT   = grantDm;
    oRAM_CE   = state == ACCESS;
    oRAM_WR   = (state == ACCESS) && latWr;
    oRAM_ADDR = (state == ACCESS) ? latAddr : '0;
    oRAM_DATA = (state == ACCESS) ? latWdata : '0;
    oIF_VALID = (state == RESP) && !winDm;
    oDM_VALID = (state == RESP) && winDm;
    oIF_DATA  = ((state == RESP) && !winDm) ? capData : '0;
    oDM_RDATA = ((state == RESP) && winDm && !latWr) ? capData : '0;
    oBUSY     = state != IDLE;
  end
  // the WAIT counter reaches RD_LAT-1 on the same edge that captures the read word
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      winDm    <= 1'b0;
      latWr    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      cnt      <= '0;
      capData  <= '0;
    end else begin
      if (grantIf || grantDm) begin
        winDm    <= grantDm;
        latWr    <= grantDm && iDM_WR;
        latAddr  <= grantDm ? iDM_ADDR : iIF_ADDR;
        latWdata <= grantDm ? iDM_WDATA : '0;
      end
      cnt <= (state == WAIT) ? cnt + 2'd1 : 2'd0;
      if ((state == ACCESS && RD_LAT == 1) || (state == WAIT && cnt == LAST)) capData <= iRAM_DATA;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench over three arbiters with RD_LAT = 1, 3 and 4 sharing one stimulus.
module tb_ram_port_arbiter;
  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  logic iIF_REQ, iDM_REQ, iDM_WR;
  logic [31:0] iIF_ADDR, iDM_ADDR, iDM_WDATA, iRAM_DATA;
  logic [2:0] ifGnt, ifValid, dmGnt, dmValid, ramCe, ramWr, busy;
  logic [31:0] ifData [3];
  logic [31:0] dmRdata [3];
  logic [31:0] ramAddr [3];
  logic [31:0] ramData [3];
  logic [1:0] expGnt;
  int nChecks = 0;
  int nFails = 0;
  always #5 iCLK = ~iCLK;
  for (genvar g = 0; g < 3; g++) begin : gDut
    ram_port_arbiter #(.RD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iIF_REQ(iIF_REQ), .iIF_ADDR(iIF_ADDR), .oIF_GNT(ifGnt[g]), .oIF_VALID(ifValid[g]), .oIF_DATA(ifData[g]),
      .iDM_REQ(iDM_REQ), .iDM_WR(iDM_WR), .iDM_ADDR(iDM_ADDR), .iDM_WDATA(iDM_WDATA),
      .oDM_GNT(dmGnt[g]), .oDM_VALID(dmValid[g]), .oDM_RDATA(dmRdata[g]),
      .oRAM_CE(ramCe[g]), .oRAM_WR(ramWr[g]), .oRAM_ADDR(ramAddr[g]), .oRAM_DATA(ramData[g]),
      .iRAM_DATA(iRAM_DATA), .oBUSY(busy[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic nextCycle();
    @(posedge iCLK);
    #1;
  endtask
  task automatic clearReq();
    iIF_REQ = 1'b0; iDM_REQ = 1'b0; iDM_WR = 1'b0;
    iIF_ADDR = '0; iDM_ADDR = '0; iDM_WDATA = '0;
  endtask
  task automatic idle(input int n);
    clearReq();
    repeat (n) nextCycle();
  endtask
  initial begin
    clearReq();
    iRAM_DATA = '0;
    iRST = 1'b1;
    iIF_REQ = 1'b1;
    iDM_REQ = 1'b1;
    repeat (2) nextCycle();
    #2;
    check("rst_gnt", {ifGnt, dmGnt}, 0);
    check("rst_busy", busy, 0);
    check("rst_ce", ramCe, 0);
    // first request presented in the cycle reset releases
    nextCycle();
    iRST = 1'b0; iIF_REQ = 1'b0; iDM_REQ = 1'b1; iDM_WR = 1'b0; iDM_ADDR = 32'h40;
    #2 check("first_gnt", dmGnt, 3'b111);
    nextCycle();
    clearReq();
    #2 check("rst_acc_ce", ramCe[1], 1);
    check("rst_acc_addr", ramAddr[1], 32'h40);
    nextCycle();
    #2 check("rst_wait_busy", busy[1], 1);
    iRST = 1'b1;
    #1 check("rst_mid_outs", {ifValid[1], dmValid[1], busy[1], ramCe[1], ramWr[1], ifGnt[1], dmGnt[1]}, 0);
    check("rst_mid_addr", ramAddr[1], 0);
    nextCycle();
    iRST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2 check("rst_no_valid", {dmValid, ifValid, busy}, 0);
      nextCycle();
    end
    iIF_REQ = 1'b1; iIF_ADDR = 32'h100;
    #2 check("if_gnt", {ifGnt[0], dmGnt[0]}, 2'b10);
    nextCycle();
    iIF_REQ = 1'b0; iIF_ADDR = '0; iRAM_DATA = 32'h537;
    #2 check("if_ce_wr", {ramCe[0], ramWr[0]}, 2'b10);
    check("if_addr", ramAddr[0], 32'h100);
    nextCycle();
    iRAM_DATA = 32'hFFFF0000;
    #2 check("if_valid", {ifValid[0], dmValid[0]}, 2'b10);
    check("if_data", ifData[0], 32'h537);
    check("if_dm_rdata", dmRdata[0], 0);
    nextCycle();
    #2 check("if_idle", {busy[0], ifValid[0]}, 0);
    idle(6);
    iDM_REQ = 1'b1; iDM_WR = 1'b1; iDM_ADDR = 32'h2000; iDM_WDATA = 32'hDEADBEEF;
    #2 check("wr_gnt", {ifGnt[0], dmGnt[0]}, 2'b01);
    nextCycle();
    clearReq();
    iRAM_DATA = 32'h12345678;
    #2 check("wr_ce_wr", {ramCe[0], ramWr[0], ifValid[0]}, 3'b110);
    check("wr_addr", ramAddr[0], 32'h2000);
    check("wr_data", ramData[0], 32'hDEADBEEF);
    nextCycle();
    #2 check("wr_valid", {dmValid[0], ifValid[0]}, 2'b10);
    check("wr_rdata", dmRdata[0], 0);
    nextCycle();
    #2 check("wr_idle", {busy[0], ifValid[0], dmValid[0]}, 0);
    idle(4);
    iDM_REQ = 1'b1; iDM_WR = 1'b0; iDM_ADDR = 32'h40;
    #2 check("rd4_gnt", dmGnt[2], 1);
    nextCycle();
    clearReq();
    iRAM_DATA = 32'h11111111;
    #2 check("rd4_ce", {ramCe[2], busy[2]}, 2'b11);
    check("rd4_addr", ramAddr[2], 32'h40);
    for (int i = 2; i < 4; i++) begin
      nextCycle();
      #2 check("rd4_wait", {ramCe[2], busy[2], dmValid[2]}, 3'b010);
    end
    nextCycle();
    iRAM_DATA = 32'hCAFEF00D;
    #2 check("rd4_c4", {ramCe[2], busy[2], dmValid[2]}, 3'b010);
    nextCycle();
    iRAM_DATA = 32'h0BADBAD0;
    #2 check("rd4_valid", {dmValid[2], busy[2], ifValid[2]}, 3'b110);
    check("rd4_data", dmRdata[2], 32'hCAFEF00D);
    nextCycle();
    #2 check("rd4_idle", {busy[2], dmValid[2]}, 0);
    idle(4);
    nextCycle();
    iRST = 1'b1;
    nextCycle();
    iRST = 1'b0;
    iIF_REQ = 1'b1; iDM_REQ = 1'b1; iIF_ADDR = 32'h10; iDM_ADDR = 32'h20;
    for (int i = 0; i < 9; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expGnt = (i % 3 != 0) ? 2'b00 : ((i == 3) ? 2'b01 : 2'b10);
`else
      expGnt = (i % 3 != 0) ? 2'b00 : 2'b01;
`endif
      #2 check("b2b_gnt", {ifGnt[0], dmGnt[0]}, expGnt);
      nextCycle();
    end
    idle(8);
    iDM_REQ = 1'b1; iDM_WR = 1'b0; iDM_ADDR = 32'h50;
    #2 check("busy_dm_gnt", dmGnt[0], 1);
    nextCycle();
    iDM_REQ = 1'b0; iIF_REQ = 1'b1; iIF_ADDR = 32'h300;
    #2 check("busy_c1", {ifGnt[0], ramCe[0]}, 2'b01);
    nextCycle();
    #2 check("busy_c2", {ifGnt[0], ramCe[0], dmValid[0]}, 3'b001);
    nextCycle();
    #2 check("busy_c3_gnt", {ifGnt[0], busy[0]}, 2'b10);
    nextCycle();
    clearReq();
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

- Shares the core's single-ported RAM between the instruction-fetch requester (IF) and the load/store data requester (DM).
- Accepts one request at a time and drives the oRAM_* bus for exactly one cycle per access.
- Waits out the RAM read latency, then returns read data or a write acknowledge to the winning requester.
- Sits between the fetch unit, the instruction-type execution blocks and the RAM.

## Interface
Parameters:
- RD_LAT, 1, cycles from the RAM access cycle (oRAM_CE=1) to iRAM_DATA being valid; legal range 1..4.

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset; asynchronous, active-high.
- iIF_REQ  in  1  fetch request; held until oIF_GNT.
- iIF_ADDR  in  32  fetch address.
- oIF_GNT  out  1  fetch request accepted this cycle.
- oIF_VALID  out  1  one-cycle pulse; oIF_DATA is valid.
- oIF_DATA  out  32  fetched word.
- iDM_REQ  in  1  data request; held until oDM_GNT.
- iDM_WR  in  1  1 = write, 0 = read.
- iDM_ADDR  in  32  data address.
- iDM_WDATA  in  32  write data.
- oDM_GNT  out  1  data request accepted this cycle.
- oDM_VALID  out  1  one-cycle pulse; read data valid, or write done.
- oDM_RDATA  out  32  read word; 0 for writes.
- oRAM_CE  out  1  RAM access strobe.
- oRAM_WR  out  1  RAM write enable; qualified by oRAM_CE.
- oRAM_ADDR  out  32  RAM address.
- oRAM_DATA  out  32  RAM write data.
- iRAM_DATA  in  32  RAM read data.
- oBUSY  out  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE → ACCESS: at least one request is present.
  - ACCESS → WAIT: read with RD_LAT > 1.
  - ACCESS → RESP: write, or read with RD_LAT = 1.
  - WAIT → RESP: counter reaches RD_LAT-1.
  - RESP → IDLE: unconditional.
- Grant: combinational, asserted only in IDLE. At most one of oIF_GNT and oDM_GNT is high. Asserted in the same cycle as the winning request.
- On the grant edge the block latches: winner id, WR (forced to 0 for IF), ADDR, WDATA.
- A requester may change or drop its request from the cycle after its grant.
- ACCESS: oRAM_CE=1, and oRAM_WR/ADDR/DATA come from the latched values. In every other state oRAM_CE, oRAM_WR, oRAM_ADDR and oRAM_DATA are 0.
- WAIT: a 2-bit counter starts at 0 on entry. iRAM_DATA is captured on the edge where the counter reaches RD_LAT-1. For RD_LAT=1 capture happens on the ACCESS edge.
- RESP:
  - Exactly one VALID pulses, for the latched winner.
  - The captured word appears on that requester's DATA output.
  - The other requester's DATA output reads 0.
  - Write responses put 0 on oDM_RDATA.
- Addresses pass through unmodified. No alignment checking and no byte enables.
- Reset (asynchronous, any state):
  - State goes to IDLE; every output is 0.
  - Latched request, counter and capture register are cleared; the round-robin pointer returns to its reset value.
  - An in-flight access is dropped: no VALID is issued for it.
  - The requester must re-issue it after reset.

## Timing
- Read, RD_LAT=L, grant in cycle 0:
  - ACCESS in cycle 1.
  - Data captured at the end of cycle L.
  - VALID in cycle L+1.
  - IDLE in cycle L+2, where the next grant can occur.
- Write: grant cycle 0, ACCESS (CE=WR=1) cycle 1, oDM_VALID cycle 2, IDLE cycle 3.
- Throughput: one access per L+2 cycles for reads and per 3 cycles for writes.
- Requests that arrive while oBUSY=1 are ignored until IDLE. There is no queueing.
- Both requests present in IDLE: resolved by the arbitration policy under Configuration.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A 1-bit last-winner register (reset value: DM) decides ties. The requester that did not win last gets the grant, so IF wins the first tie after reset.
  - The register updates on every grant, including uncontested ones.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, DM over IF. IF is granted only when iDM_REQ=0.
  - No pointer register exists.

## Test plan
- Reset values: assert iRST mid-WAIT with RD_LAT=3 → all outputs 0 immediately, state IDLE, no VALID after release. The first request after reset is granted in the cycle it is presented.
- IF read, RD_LAT=1, iIF_ADDR=0x100, RAM returns 0x00000537 in cycle 1 → CE=1/WR=0/ADDR=0x100 in cycle 1. oIF_VALID=1 with oIF_DATA=0x00000537 in cycle 2. IDLE in cycle 3.
- DM write, ADDR=0x2000, WDATA=0xDEADBEEF → cycle 1: CE=1, WR=1, ADDR=0x2000, DATA=0xDEADBEEF. Cycle 2: oDM_VALID=1, oDM_RDATA=0. oIF_VALID stays 0 throughout.
- DM read with RD_LAT=4, ADDR=0x40 → CE high only in cycle 1. oDM_VALID in cycle 5 carries the iRAM_DATA value present in cycle 4; oBUSY high in cycles 1–5.
- Simultaneous IF and DM requests held for 3 back-to-back accesses:
  - ARB_ROUND_ROBIN_EN defined → grant order IF, DM, IF.
  - Undefined → DM, DM, DM, with oIF_GNT never asserted.
- Request during busy: iIF_REQ raised in cycle 1 of a DM read (RD_LAT=1) → oIF_GNT stays 0 until cycle 3 (IDLE), then asserts. oRAM_CE is never high twice within cycles 1–2.
